// File: rtl/clock_distribution_seq_if.sv
// Control/status bundle between software-facing control and the clock distribution sequencer.
// Latency: none (wires only).
// Backpressure: none; atb_req/atb_ack form a level handshake held by the requester until acked.
// Ports:
//   en, supply_ok, atb_req, atb_sel : requester -> sequencer
//   pdb, atb_ena, ready, atb_ack, fault, state : sequencer -> requester / analog block
interface clock_distribution_seq_if;
  logic       en;
  logic       supply_ok;
  logic       atb_req;
  logic [1:0] atb_sel;
  logic       pdb;
  logic [1:0] atb_ena;
  logic       ready;
  logic       atb_ack;
  logic       fault;
  logic [2:0] state;

  modport master (
    output en, supply_ok, atb_req, atb_sel,
    input  pdb, atb_ena, ready, atb_ack, fault, state
  );

  modport slave (
    input  en, supply_ok, atb_req, atb_sel,
    output pdb, atb_ena, ready, atb_ack, fault, state
  );
endinterface

// File: rtl/clock_distribution_seq.sv
// Sequencer for the IDAC clock distribution block: power-up, test-bus select, fault power-down.
// Latency: all outputs registered; every input change is visible one cycle later.
// Backpressure: one test-bus request at a time; atb_ack held until atb_req drops.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of clock_distribution_seq_if (en/supply_ok/atb_req/atb_sel in,
//              pdb/atb_ena/ready/atb_ack/fault/state out)
module clock_distribution_seq #(
  parameter int CNT_W          = 8,
  parameter int SETTLE_CYC     = 16,
  parameter int CLK_SETTLE_CYC = 8,
  parameter int ATB_SETTLE_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  clock_distribution_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    PWRUP      = 3'd1,
    CLKON      = 3'd2,
    READY      = 3'd3,
    ATB_SETTLE = 3'd4,
    ATB_VALID  = 3'd5,
    FAULT      = 3'd6
  } state_t;

  // Counter reload values: a state lasting N cycles loads N-1 on entry.
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CLK_LD    = CNT_W'(CLK_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ATB_LD    = CNT_W'(ATB_SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       atb_ena_q, atb_ena_d;
  logic             pdb_q, pdb_d;
  logic             ready_q, ready_d;
  logic             ack_q, ack_d;
  logic             fault_q, fault_d;
  logic             sup_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      atb_ena_q <= 2'b00;
      pdb_q     <= 1'b0;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      atb_ena_q <= atb_ena_d;
      pdb_q     <= pdb_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    // Free-running decrement that parks at zero; states reload it on entry.
    cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    atb_ena_d = atb_ena_q;
    // Supply is only watched once pdb is released; during PWRUP a dip just restarts settling.
    sup_fault = !bus.supply_ok &&
                (state_q inside {CLKON, READY, ATB_SETTLE, ATB_VALID});

    if (!bus.en) begin
      state_d = OFF;
    end else if (sup_fault) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        OFF: begin
          state_d = PWRUP;
          cnt_d   = SETTLE_LD;
        end
        PWRUP: begin
          if (!bus.supply_ok) begin
            cnt_d = SETTLE_LD;
          end else if (cnt_q == '0) begin
            state_d = CLKON;
            cnt_d   = CLK_LD;
          end
        end
        CLKON: begin
          if (cnt_q == '0) state_d = READY;
        end
        READY: begin
          if (bus.atb_req) begin
            state_d   = ATB_SETTLE;
            cnt_d     = ATB_LD;
            atb_ena_d = bus.atb_sel;
          end
        end
        ATB_SETTLE: begin
          // Abandoned request wins over settle completion: no ack is ever issued.
          if (!bus.atb_req)        state_d = READY;
          else if (cnt_q == '0)    state_d = ATB_VALID;
        end
        ATB_VALID: begin
          if (!bus.atb_req) state_d = READY;
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = OFF;
        end
      endcase
    end

    // Outputs decoded from the next state so they register alongside it.
    if (!(state_d inside {ATB_SETTLE, ATB_VALID})) atb_ena_d = 2'b00;
    pdb_d   = state_d inside {CLKON, READY, ATB_SETTLE, ATB_VALID};
    ready_d = state_d inside {READY, ATB_SETTLE, ATB_VALID};
    ack_d   = (state_d == ATB_VALID);
    fault_d = (state_d == FAULT);
  end

  assign bus.state   = state_q;
  assign bus.pdb     = pdb_q;
  assign bus.atb_ena = atb_ena_q;
  assign bus.ready   = ready_q;
  assign bus.atb_ack = ack_q;
  assign bus.fault   = fault_q;

endmodule

// File: tb/tb_clock_distribution_seq.sv
// Bench for clock_distribution_seq: per-cycle expected output words queued with the stimulus,
// compared one cycle later against the registered outputs.
// Backpressure: n/a.
module tb_clock_distribution_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_distribution_seq_if bus();

  clock_distribution_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int step     = 0;
  logic [8:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, act, exp);
    end
  endtask

  // Packed word: {state, pdb, atb_ena, ready, atb_ack, fault}
  function automatic logic [8:0] mk(input logic [2:0] st, input logic pdb,
                                    input logic [1:0] ena, input logic rdy,
                                    input logic ack, input logic flt);
    return {st, pdb, ena, rdy, ack, flt};
  endfunction

  localparam logic [8:0] E_OFF   = {3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [8:0] E_PWRUP = {3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [8:0] E_CLKON = {3'd2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [8:0] E_READY = {3'd3, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
  localparam logic [8:0] E_FAULT = {3'd6, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};

  function automatic logic [8:0] e_settle(input logic [1:0] ena);
    return mk(3'd4, 1'b1, ena, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic logic [8:0] e_valid(input logic [1:0] ena);
    return mk(3'd5, 1'b1, ena, 1'b1, 1'b1, 1'b0);
  endfunction

  // Queue the expectation for the edge about to happen, then move to the next negedge
  // where the next stimulus is applied.
  task automatic cyc(input logic [8:0] e);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc_n(input int n, input logic [8:0] e);
    for (int i = 0; i < n; i++) cyc(e);
  endtask

  // en already high and supply good: 16 PWRUP, 8 CLKON, then READY.
  task automatic powerup();
    cyc_n(16, E_PWRUP);
    cyc_n(8, E_CLKON);
    cyc(E_READY);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      logic [8:0] e;
      e = sb.pop_front();
      chk($sformatf("step%0d", step),
          {23'd0, bus.state, bus.pdb, bus.atb_ena, bus.ready, bus.atb_ack, bus.fault},
          {23'd0, e});
      step++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed step %0d", step);
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.supply_ok = 1'b1;
    bus.atb_req   = 1'b0;
    bus.atb_sel   = 2'b00;

    // 1: reset, then power-up timing (pdb at 17th edge, ready at 25th)
    cyc_n(2, E_OFF);
    rst    = 1'b0;
    bus.en = 1'b1;
    powerup();

    // 2: request sel=11, ack after 4 settle cycles, release
    bus.atb_req = 1'b1; bus.atb_sel = 2'b11;
    cyc_n(4, e_settle(2'b11));
    cyc_n(3, e_valid(2'b11));
    bus.atb_req = 1'b0;
    cyc(E_READY);
    cyc(E_READY);
    // sel=00 is a real request ending in ack with atb_ena=00
    bus.atb_req = 1'b1; bus.atb_sel = 2'b00;
    cyc_n(4, e_settle(2'b00));
    cyc(e_valid(2'b00));
    bus.atb_req = 1'b0;
    cyc(E_READY);
    // request abandoned during settle: back to READY with no ack
    bus.atb_req = 1'b1; bus.atb_sel = 2'b10;
    cyc_n(2, e_settle(2'b10));
    bus.atb_req = 1'b0;
    cyc_n(2, E_READY);

    // 4: supply fault during ATB_VALID is sticky until en drops
    bus.atb_req = 1'b1; bus.atb_sel = 2'b01;
    cyc_n(4, e_settle(2'b01));
    cyc(e_valid(2'b01));
    bus.supply_ok = 1'b0;
    cyc(E_FAULT);
    bus.supply_ok = 1'b1;
    cyc_n(2, E_FAULT);
    bus.atb_req = 1'b0;
    cyc(E_FAULT);
    bus.en = 1'b0;
    cyc_n(2, E_OFF);

    // 3: supply dip mid-PWRUP restarts the settle count; pdb held low
    bus.en = 1'b1;
    cyc_n(5, E_PWRUP);
    bus.supply_ok = 1'b0;
    cyc_n(3, E_PWRUP);
    bus.supply_ok = 1'b1;
    cyc_n(15, E_PWRUP);
    cyc_n(8, E_CLKON);
    cyc(E_READY);

    // 5: en drop during ATB_SETTLE, atb_sel wiggling after capture is ignored
    bus.atb_req = 1'b1; bus.atb_sel = 2'b10;
    cyc(e_settle(2'b10));
    bus.atb_sel = 2'b01;
    cyc(e_settle(2'b10));
    bus.atb_sel = 2'b11;
    cyc(e_settle(2'b10));
    bus.atb_sel = 2'b00; bus.en = 1'b0;
    cyc(E_OFF);
    bus.atb_req = 1'b0;
    cyc(E_OFF);

    // 6: one-cycle reset in READY, then full power-up again
    bus.en = 1'b1;
    powerup();
    rst = 1'b1;
    cyc(E_OFF);
    rst = 1'b0;
    powerup();

    // Supply fault in CLKON, en drop with supply still bad goes to OFF not FAULT
    bus.en = 1'b0;
    cyc(E_OFF);
    bus.en = 1'b1;
    cyc_n(16, E_PWRUP);
    cyc_n(3, E_CLKON);
    bus.supply_ok = 1'b0;
    cyc(E_FAULT);
    bus.en = 1'b0;
    cyc_n(2, E_OFF);

    @(posedge clk);
    #2;
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
